// File: rtl/round_pkg.sv
// Shared definitions for the guessing-game round controller:
// state codes, default round timing, and the per-level time load rule.
package round_pkg;

   typedef enum logic [2:0] {
      ST_WELCOME = 3'd0,
      ST_READY   = 3'd1,
      ST_GEN     = 3'd2,
      ST_PLAY    = 3'd3,
      ST_LOSE    = 3'd4
   } round_state_t;

   localparam int BASE_TIME_DEF = 30;
   localparam int MIN_TIME_DEF  = 3;
   localparam int TIME_W        = 5;

   // Each won level removes two seconds, never dropping below the floor.
   // Plain int arithmetic covers the full signed range of the level-based subtraction.
   function automatic logic [TIME_W-1:0] load_time(input int lvl, input int base_t, input int min_t);
      int t;
      t = base_t - 2 * lvl;
      if (t < min_t) t = min_t;
      return t[TIME_W-1:0];
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles;
// clr restarts the count so the first tick lands exactly TICK_DIV cycles later.
module tick_prescaler #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] count_reg;
   logic [CW-1:0] count_next;

   assign tick = en && (count_reg == CW'(TICK_DIV - 1));

   always_comb begin
      count_next = count_reg;
      if (clr)
         count_next = '0;
      else if (en)
         count_next = tick ? '0 : count_reg + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

endmodule

// File: rtl/round_sequencer.sv
// Round controller: requests a target, runs the countdown, judges the guess
// and tracks level and win/lose outcome. All outputs come straight from registers.
module round_sequencer
   import round_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int BASE_TIME = BASE_TIME_DEF,
   parameter int MIN_TIME  = MIN_TIME_DEF,
   parameter int LVL_W     = 8,
   parameter int NUM_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_pulse,
   input  logic [NUM_W-1:0] guess,
   input  logic             gen_ack,
   input  logic [NUM_W-1:0] gen_value,
   output logic             gen_req,
   output logic [2:0]       state,
   output logic [LVL_W-1:0] level,
   output logic [4:0]       time_left,
   output logic             timer_run,
   output logic [NUM_W-1:0] target,
   output logic             win_pulse,
   output logic             lose_pulse
);

   round_state_t     state_reg, state_next;
   logic [LVL_W-1:0] level_reg, level_next;
   logic [4:0]       time_left_reg, time_left_next;
   logic             timer_run_reg, timer_run_next;
   logic [NUM_W-1:0] target_reg, target_next;
   logic             gen_req_reg, gen_req_next;
   logic             win_reg, win_next;
   logic             lose_reg, lose_next;
   logic             presc_clr;
   logic             tick;

   tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (presc_clr),
      .en    (timer_run_reg),
      .tick  (tick)
   );

   always_comb begin
      state_next     = state_reg;
      level_next     = level_reg;
      time_left_next = time_left_reg;
      timer_run_next = timer_run_reg;
      target_next    = target_reg;
      gen_req_next   = gen_req_reg;
      win_next       = 1'b0;
      lose_next      = 1'b0;
      presc_clr      = 1'b0;

      case (state_reg)
         ST_WELCOME: begin
            if (btn_pulse) state_next = ST_READY;
         end
         ST_READY: begin
            if (btn_pulse) begin
               state_next     = ST_GEN;
               gen_req_next   = 1'b1;
               time_left_next = load_time(int'(level_reg), BASE_TIME, MIN_TIME);
            end
         end
         ST_GEN: begin
            if (gen_ack) begin
               target_next    = gen_value;
               gen_req_next   = 1'b0;
               timer_run_next = 1'b1;
               presc_clr      = 1'b1;
               state_next     = ST_PLAY;
            end
         end
         ST_PLAY: begin
            if (tick) time_left_next = time_left_reg - 1'b1;
            // An expiring tick outranks a press landing on the same cycle.
            if (tick && time_left_reg == 5'd1) begin
               lose_next      = 1'b1;
               timer_run_next = 1'b0;
               state_next     = ST_LOSE;
            end else if (btn_pulse) begin
               timer_run_next = 1'b0;
               if (guess == target_reg) begin
                  win_next   = 1'b1;
                  state_next = ST_READY;
                  if (level_reg != '1) level_next = level_reg + 1'b1;
               end else begin
                  lose_next  = 1'b1;
                  state_next = ST_LOSE;
               end
            end
         end
         ST_LOSE: begin
            if (btn_pulse) begin
               state_next = ST_READY;
               level_next = '0;
            end
         end
         default: begin
            state_next     = ST_WELCOME;
            timer_run_next = 1'b0;
            gen_req_next   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_WELCOME;
         level_reg     <= '0;
         time_left_reg <= 5'(BASE_TIME);
         timer_run_reg <= 1'b0;
         target_reg    <= '0;
         gen_req_reg   <= 1'b0;
         win_reg       <= 1'b0;
         lose_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         level_reg     <= level_next;
         time_left_reg <= time_left_next;
         timer_run_reg <= timer_run_next;
         target_reg    <= target_next;
         gen_req_reg   <= gen_req_next;
         win_reg       <= win_next;
         lose_reg      <= lose_next;
      end
   end

   assign state      = state_reg;
   assign level      = level_reg;
   assign time_left  = time_left_reg;
   assign timer_run  = timer_run_reg;
   assign target     = target_reg;
   assign gen_req    = gen_req_reg;
   assign win_pulse  = win_reg;
   assign lose_pulse = lose_reg;

endmodule

// File: doc/round_sequencer.md
# round_sequencer

Synchronous controller for one round of the binary guessing game. It sequences the number generator through a req/ack handshake, loads and runs the per-round countdown from the current level, compares the player's switch value against the captured target, and tracks level and win/lose outcome. It sits between the debounced button front-end, the number generator and the display drivers, and replaces the level/time bookkeeping formerly done with button and timer edges as clocks.

## Interface
- TICK_DIV, 50_000_000: clock cycles per countdown second (≥2)
- BASE_TIME, 30: seconds loaded at level 0
- MIN_TIME, 3: floor on loaded time
- LVL_W, 8: level counter width
- NUM_W, 8: target/guess width

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- btn_pulse  in  1  one-cycle press pulse, already debounced upstream
- guess  in  NUM_W  player switch value, sampled on btn_pulse
- gen_ack  in  1  generator has gen_value valid
- gen_value  in  NUM_W  generated target
- gen_req  out  1  request new target
- state  out  3  current state code
- level  out  LVL_W  rounds won since last loss
- time_left  out  5  seconds remaining
- timer_run  out  1  countdown active
- target  out  NUM_W  captured target (shown on loss)
- win_pulse  out  1  one-cycle correct guess
- lose_pulse  out  1  one-cycle loss (wrong or timeout)

## Operation
- Reset values: state WELCOME, level 0, time_left BASE_TIME, timer_run 0, gen_req 0, target 0, win_pulse 0, lose_pulse 0, prescaler 0.
- States/codes: WELCOME 0, READY 1, GEN 2, PLAY 3, LOSE 4.
- WELCOME: btn_pulse → READY.
- READY: btn_pulse → GEN, gen_req←1, time_left←max(BASE_TIME − 2·level, MIN_TIME); subtraction in LVL_W+2 signed bits, negative results clamp to MIN_TIME.
- GEN: gen_req held 1 until gen_ack; on gen_ack: target←gen_value, gen_req←0, timer_run←1, prescaler←0, → PLAY. btn_pulse ignored.
- PLAY: prescaler counts 0..TICK_DIV−1, tick at terminal count; tick decrements time_left. Tick taking time_left 1→0: → LOSE, lose_pulse.
- PLAY btn_pulse with guess==target: level←level+1 (saturate at all-ones), win_pulse, → READY. Mismatch: lose_pulse, → LOSE.
- Simultaneous btn_pulse and expiring tick: timeout wins → LOSE, level unchanged, no win_pulse.
- timer_run cleared on every exit from PLAY; time_left holds last value outside PLAY until next load.
- LOSE: btn_pulse → READY, level←0. target held for display.
- gen_ack outside GEN ignored.

## Timing
- All outputs registered; btn_pulse at edge N → new state/outputs visible after edge N (one-cycle latency).
- gen_req rises the cycle after the READY press; falls the cycle after gen_ack sampled high.
- First tick TICK_DIV cycles after entering PLAY; time_left update visible the cycle after tick.
- Full round from BASE_TIME to timeout: 30·TICK_DIV cycles.
- win_pulse/lose_pulse exactly one cycle, coincident with state change.
- rst_n low at any time (incl. mid-GEN, mid-PLAY): outputs return to reset values immediately; gen_req drops asynchronously.

## Structure
- Package round_pkg: state enum/codes, BASE_TIME/MIN_TIME defaults, time-load function (clamped subtraction).
- Sub-module tick_prescaler: counter with synchronous clear and enable, one-cycle tick output, parameter TICK_DIV.
- Remainder (FSM, level, time_left, target) in round_sequencer.

## Test plan
- Reset, TICK_DIV=4, btn twice → state 1 then 2, gen_req 1; gen_ack after 3 cycles with 0xA5 → target 0xA5, state 3, time_left 30, gen_req 0.
- PLAY, guess 0xA5 + btn → win_pulse 1 cycle, level 1, state 1; next READY press loads time_left 28.
- No press in PLAY, TICK_DIV=4 → time_left 0 after 120 cycles, lose_pulse, state 4; btn → state 1, level 0.
- Force level 14 → load 3 (30−28 clamped); level 255 + correct guess → level stays 255, load 3.
- guess==target and btn on the cycle of final tick → state 4, lose_pulse, win_pulse 0, level unchanged.
- rst_n low mid-GEN and mid-PLAY → gen_req 0, timer_run 0, state 0, level 0, time_left 30 immediately.
